// File: rtl/wave_meter_pkg.sv
// ============================================================================
// Module : wave_meter_pkg
// Brief  : Shared state encoding and default sizing for the wave meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wave_meter_pkg;

    localparam int DW_DEFAULT   = 8;
    localparam int CW_DEFAULT   = 16;
    localparam int HYST_DEFAULT = 8;

    typedef enum logic [0:0] {
        S_SYNC = 1'b0,
        S_MEAS = 1'b1
    } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/wave_meter_xing_detector.sv
// ============================================================================
// Module : xing_detector
// Brief  : Hysteresis comparator producing a rising-crossing pulse per sample.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xing_detector #(
    parameter int DW   = 8,
    parameter int HYST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_sample,
    input  logic [DW-1:0] i_threshold,
    input  logic          i_disarm,
    output logic          o_xing
);

    localparam logic [DW:0] c_HYST = (DW+1)'(HYST);

    logic [DW:0]   w_hi_sum;
    logic [DW-1:0] w_hi_th;
    logic [DW-1:0] w_lo_th;
    logic          r_armed;

    // Band edges clamp to the sample range instead of wrapping.
    always_comb begin
        w_hi_sum = {1'b0, i_threshold} + c_HYST;
        w_hi_th  = w_hi_sum[DW] ? {DW{1'b1}} : w_hi_sum[DW-1:0];
        w_lo_th  = ({1'b0, i_threshold} < c_HYST) ? '0
                 : DW'({1'b0, i_threshold} - c_HYST);
    end

    assign o_xing = i_valid && r_armed && (i_sample >= w_hi_th);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (i_valid) begin
            if (o_xing || i_disarm) begin
                r_armed <= 1'b0;
            end else if (i_sample <= w_lo_th) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wave_meter.sv
// ============================================================================
// Module : wave_meter
// Brief  : Measures period and min/max amplitude of each waveform cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wave_meter
    import wave_meter_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int CW   = CW_DEFAULT,
    parameter int HYST = HYST_DEFAULT
) (
    input  logic          clk_100kHz,
    input  logic          rst_,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    input  logic [DW-1:0] threshold,
    output logic [CW-1:0] period_out,
    output logic [DW-1:0] amp_max,
    output logic [DW-1:0] amp_min,
    output logic          meas_valid,
    output logic          timeout
);

    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    meter_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_run_max;
    logic [DW-1:0] r_run_min;
    logic [CW-1:0] r_period;
    logic [DW-1:0] r_amp_max;
    logic [DW-1:0] r_amp_min;
    logic          r_meas_valid;
    logic          r_timeout;
    logic          w_xing;
    logic          w_cycle_lost;

    // A cycle that outgrows the counter drops the arming so resync needs a fresh low excursion.
    assign w_cycle_lost = sample_valid && (r_state == S_MEAS) && !w_xing
                       && (r_cnt == c_CNT_MAX);

    xing_detector #(
        .DW   (DW),
        .HYST (HYST)
    ) u_xing (
        .clk         (clk_100kHz),
        .rst         (rst_),
        .i_valid     (sample_valid),
        .i_sample    (sample_in),
        .i_threshold (threshold),
        .i_disarm    (w_cycle_lost),
        .o_xing      (w_xing)
    );

    always_ff @(posedge clk_100kHz) begin
        if (rst_) begin
            r_state      <= S_SYNC;
            r_cnt        <= '0;
            r_run_max    <= '0;
            r_run_min    <= '0;
            r_period     <= '0;
            r_amp_max    <= '0;
            r_amp_min    <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (sample_valid) begin
                case (r_state)
                    S_SYNC: begin
                        if (w_xing) begin
                            r_state   <= S_MEAS;
                            r_cnt     <= c_CNT_ONE;
                            r_run_max <= sample_in;
                            r_run_min <= sample_in;
                        end
                    end
                    S_MEAS: begin
                        if (w_xing) begin
                            r_period     <= r_cnt;
                            r_amp_max    <= r_run_max;
                            r_amp_min    <= r_run_min;
                            r_meas_valid <= 1'b1;
                            r_timeout    <= 1'b0;
                            // The crossing sample belongs to the cycle it opens.
                            r_cnt        <= c_CNT_ONE;
                            r_run_max    <= sample_in;
                            r_run_min    <= sample_in;
                        end else if (w_cycle_lost) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_SYNC;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                            if (sample_in > r_run_max) r_run_max <= sample_in;
                            if (sample_in < r_run_min) r_run_min <= sample_in;
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

    assign period_out = r_period;
    assign amp_max    = r_amp_max;
    assign amp_min    = r_amp_min;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire
